// File: rtl/mioc_dram_seq_pkg.sv
// rtl/mioc_dram_seq_pkg.sv - shared constants for the MIOC DRAM strobe sequencer
// Purpose : FSM state encodings, precharge counter width and default sizes
//           shared by the sequencer, its interface and the refresh extender.
// Ports   : none (package)
package mioc_dram_seq_pkg;

  // 3-bit encodings kept as plain constants so they match the legacy logic.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ROW  = 3'd1;
  localparam logic [2:0] ST_COL  = 3'd2;
  localparam logic [2:0] ST_CAS  = 3'd3;
  localparam logic [2:0] ST_REF  = 3'd4;
  localparam logic [2:0] ST_PRE  = 3'd5;

  // Wide enough for the largest precharge length (7 cycles).
  localparam int PRE_CNT_W = 3;

  localparam int DEF_N_BANKS   = 2;
  localparam int DEF_BANK_W    = 1;
  localparam int DEF_REF_XBITS = 1;

endpackage

// File: rtl/mioc_dram_seq_if.sv
// rtl/mioc_dram_seq_if.sv - buffered Z80 bus in, DRAM strobes out
// Purpose : bundles the bus-side inputs and DRAM-side outputs of the sequencer.
// Ports   : BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA6, RAM_EN, BANK, CPU_RAX (to the
//           sequencer); RA_X, RAS_N, CAS_N, MUX (from the sequencer).
//           master = bus/decode side, slave = sequencer.
interface mioc_dram_seq_if #(
  parameter int N_BANKS   = mioc_dram_seq_pkg::DEF_N_BANKS,
  parameter int BANK_W    = mioc_dram_seq_pkg::DEF_BANK_W,
  parameter int REF_XBITS = mioc_dram_seq_pkg::DEF_REF_XBITS
);
  logic                 BMREQ_N;
  logic                 BRD_N;
  logic                 N_BWR;
  logic                 BRFSH_N;
  logic                 BA6;
  logic                 RAM_EN;
  logic [BANK_W-1:0]    BANK;
  logic [REF_XBITS-1:0] CPU_RAX;
  logic [REF_XBITS-1:0] RA_X;
  logic                 RAS_N;
  logic [N_BANKS-1:0]   CAS_N;
  logic                 MUX;

  modport master (
    output BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA6, RAM_EN, BANK, CPU_RAX,
    input  RA_X, RAS_N, CAS_N, MUX
  );

  modport slave (
    input  BMREQ_N, BRD_N, N_BWR, BRFSH_N, BA6, RAM_EN, BANK, CPU_RAX,
    output RA_X, RAS_N, CAS_N, MUX
  );
endinterface

// File: rtl/mioc_dram_seq_ref_ext.sv
// rtl/mioc_dram_seq_ref_ext.sv - refresh row extension above Z80 R[6:0]
// Purpose : counts wraps of the Z80 7-bit refresh counter (seen as BA6 falling
//           between successive refreshes) and drives the extended row bits.
// Ports   : clk, rst        clock, synchronous active-high reset
//           ref_entry       pulse on the edge that enters a refresh cycle
//           in_ref          sequencer is currently in a refresh cycle
//           ba6             bus address bit 6 (R[6] during refresh)
//           cpu_rax         CPU row bits for normal accesses
//           ra_x            extended row address (combinational)
module mioc_ref_ext #(
  parameter int REF_XBITS = mioc_dram_seq_pkg::DEF_REF_XBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ref_entry,
  input  logic                 in_ref,
  input  logic                 ba6,
  input  logic [REF_XBITS-1:0] cpu_rax,
  output logic [REF_XBITS-1:0] ra_x
);

  logic [REF_XBITS-1:0] ref_cnt;
  logic                 last_ba6;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt  <= '0;
      last_ba6 <= 1'b0;
    end else if (ref_entry) begin
      // R[6] going 1 -> 0 between two refreshes means R[6:0] wrapped.
      if (last_ba6 && !ba6) begin
        ref_cnt <= ref_cnt + REF_XBITS'(1);
      end
      last_ba6 <= ba6;
    end
  end

  assign ra_x = in_ref ? ref_cnt : cpu_rax;

endmodule

// File: rtl/mioc_dram_seq.sv
// rtl/mioc_dram_seq.sv - parametrised DRAM RAS/CAS/MUX strobe sequencer
// Purpose : turns the buffered Z80 memory cycle into RAS_N, per-bank CAS_N and
//           MUX, with RAS-only refresh using an extended row counter.
// Ports   : B_PHI           clock, all state changes on the rising edge
//           RST             synchronous reset, active-high
//           bus (slave)     Z80 bus inputs, decode inputs, DRAM strobe outputs
//           REF_LATE        sticky refresh-overdue flag (MIOC_REF_WDOG_EN only)
// Config  : define MIOC_REF_WDOG_EN to build the refresh watchdog and REF_LATE.
module mioc_dram_seq
  import mioc_dram_seq_pkg::*;
#(
  parameter int N_BANKS       = DEF_N_BANKS,
  parameter int BANK_W        = DEF_BANK_W,
  parameter int REF_XBITS     = DEF_REF_XBITS,
  parameter int PRECHARGE_CYC = 1,
  parameter int REF_TIMEOUT   = 64
) (
  input  logic B_PHI,
  input  logic RST,
  mioc_dram_seq_if.slave bus
`ifdef MIOC_REF_WDOG_EN
  ,
  output logic REF_LATE
`endif
);

  if (PRECHARGE_CYC < 1 || PRECHARGE_CYC > 7 || REF_TIMEOUT < 1 ||
      (1 << BANK_W) < N_BANKS) begin : g_bad_param
    $error("mioc_dram_seq: parameter out of range");
  end

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [PRE_CNT_W-1:0] pre_cnt;
  logic [N_BANKS-1:0]   cas_sel_n;
  logic                 ref_entry;
  logic                 access;

  assign access    = !bus.BRD_N || !bus.N_BWR;
  assign ref_entry = (state == ST_IDLE) && (next_state == ST_REF);

  // Only BMREQ_N ends a cycle; BRFSH_N is looked at solely from IDLE.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (!bus.BMREQ_N) begin
          if (!bus.BRFSH_N)   next_state = ST_REF;
          else if (bus.RAM_EN) next_state = ST_ROW;
        end
      end
      ST_ROW:  next_state = bus.BMREQ_N ? ST_PRE : ST_COL;
      ST_COL: begin
        if (bus.BMREQ_N)  next_state = ST_PRE;
        else if (access)  next_state = ST_CAS;
      end
      ST_CAS:  if (bus.BMREQ_N) next_state = ST_PRE;
      ST_REF:  if (bus.BMREQ_N) next_state = ST_PRE;
      ST_PRE: begin
        if (pre_cnt == PRE_CNT_W'(PRECHARGE_CYC - 1)) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Out-of-range BANK values match no bit, so no CAS fires.
  always_comb begin
    cas_sel_n = '1;
    for (int i = 0; i < N_BANKS; i++) begin
      cas_sel_n[i] = (bus.BANK != BANK_W'(i));
    end
  end

  // Strobes are registered from next_state so they change on the same edge
  // as the state that owns them.
  always_ff @(posedge B_PHI) begin
    if (RST) begin
      state     <= ST_IDLE;
      pre_cnt   <= '0;
      bus.RAS_N <= 1'b1;
      bus.CAS_N <= '1;
      bus.MUX   <= 1'b0;
    end else begin
      state     <= next_state;
      pre_cnt   <= (state == ST_PRE) ? pre_cnt + PRE_CNT_W'(1) : '0;
      bus.RAS_N <= !((next_state == ST_ROW) || (next_state == ST_COL) ||
                     (next_state == ST_CAS) || (next_state == ST_REF));
      bus.MUX   <= (next_state == ST_COL) || (next_state == ST_CAS);
      bus.CAS_N <= (next_state == ST_CAS) ? cas_sel_n : '1;
    end
  end

  mioc_ref_ext #(
    .REF_XBITS (REF_XBITS)
  ) u_ref_ext (
    .clk       (B_PHI),
    .rst       (RST),
    .ref_entry (ref_entry),
    .in_ref    (state == ST_REF),
    .ba6       (bus.BA6),
    .cpu_rax   (bus.CPU_RAX),
    .ra_x      (bus.RA_X)
  );

`ifdef MIOC_REF_WDOG_EN
  localparam int WD_W = $clog2(REF_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge B_PHI) begin
    if (RST) begin
      wd_cnt   <= '0;
      REF_LATE <= 1'b0;
    end else begin
      if (ref_entry) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_W'(REF_TIMEOUT)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_cnt == WD_W'(REF_TIMEOUT)) begin
        REF_LATE <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mioc_dram_seq.sv
// tb/tb_mioc_dram_seq.sv - scoreboard bench for the MIOC DRAM strobe sequencer
module tb_mioc_dram_seq;

  logic B_PHI = 1'b0;
  logic RST;
`ifdef MIOC_REF_WDOG_EN
  logic REF_LATE;
`endif

  always #5 B_PHI = ~B_PHI;

  mioc_dram_seq_if #(.N_BANKS(2), .BANK_W(2), .REF_XBITS(1)) bus ();

  mioc_dram_seq #(
    .N_BANKS       (2),
    .BANK_W        (2),
    .REF_XBITS     (1),
    .PRECHARGE_CYC (2),
    .REF_TIMEOUT   (64)
  ) dut (
    .B_PHI    (B_PHI),
    .RST      (RST),
    .bus      (bus)
`ifdef MIOC_REF_WDOG_EN
    ,
    .REF_LATE (REF_LATE)
`endif
  );

  typedef struct {
    logic       ras;
    logic [1:0] cas;
    logic       mux;
    logic       rax;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  // Drive one cycle of inputs and queue what the outputs must be after the
  // next rising edge.
  task automatic step(input logic rst_i, input logic mreq, input logic rd,
                      input logic wr, input logic rfsh, input logic ba6,
                      input logic ram_en, input logic [1:0] bank,
                      input logic rax_in, input logic e_ras,
                      input logic [1:0] e_cas, input logic e_mux,
                      input logic e_rax);
    exp_t e;
    RST         = rst_i;
    bus.BMREQ_N = mreq;
    bus.BRD_N   = rd;
    bus.N_BWR   = wr;
    bus.BRFSH_N = rfsh;
    bus.BA6     = ba6;
    bus.RAM_EN  = ram_en;
    bus.BANK    = bank;
    bus.CPU_RAX = rax_in;
    e.ras = e_ras; e.cas = e_cas; e.mux = e_mux; e.rax = e_rax; e.id = step_id;
    sb.push_back(e);
    step_id++;
    @(negedge B_PHI);
  endtask

  task automatic idle(input logic rax_in);
    step(0, 1, 1, 1, 1, 0, 0, 2'd0, rax_in, 1, 2'b11, 0, rax_in);
  endtask

  // Refresh cycle with PRECHARGE_CYC=2: REF, PRE, PRE, IDLE.
  task automatic refresh(input logic ba6, input logic e_row);
    step(0, 0, 1, 1, 0, ba6, 0, 2'd0, 1'b1, 0, 2'b11, 0, e_row);
    step(0, 1, 1, 1, 1, ba6, 0, 2'd0, 1'b1, 1, 2'b11, 0, 1'b1);
    idle(1'b1);
    idle(1'b1);
  endtask

  // Monitor: one expected entry per edge, compared 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge B_PHI);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.RAS_N !== e.ras) begin
          errors++;
          $display("FAIL ras_n step %0d got %b want %b", e.id, bus.RAS_N, e.ras);
        end
        checks++;
        if (bus.CAS_N !== e.cas) begin
          errors++;
          $display("FAIL cas_n step %0d got %b want %b", e.id, bus.CAS_N, e.cas);
        end
        checks++;
        if (bus.MUX !== e.mux) begin
          errors++;
          $display("FAIL mux step %0d got %b want %b", e.id, bus.MUX, e.mux);
        end
        checks++;
        if (bus.RA_X !== e.rax) begin
          errors++;
          $display("FAIL ra_x step %0d got %b want %b", e.id, bus.RA_X, e.rax);
        end
      end
    end
  end

  initial begin
    logic [8:0] iv;
    RST = 1'b1;
    bus.BMREQ_N = 1; bus.BRD_N = 1; bus.N_BWR = 1; bus.BRFSH_N = 1;
    bus.BA6 = 0; bus.RAM_EN = 0; bus.BANK = 0; bus.CPU_RAX = 0;
    @(negedge B_PHI);

    // Reset state
    step(1, 1, 1, 1, 1, 0, 0, 2'd0, 1'b0, 1, 2'b11, 0, 0);
    idle(1'b0);

    // 257 refreshes, BA6 = R[6] of refresh i; row extension = i[7]
    for (int i = 0; i <= 256; i++) begin
      iv = i[8:0];
      refresh(iv[6], iv[7]);
    end

    // Read, BANK=1, BMREQ_N low for 3 cycles
    step(0, 0, 0, 1, 1, 0, 1, 2'd1, 1'b0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 2'd1, 1'b0, 0, 2'b11, 1, 0);
    step(0, 0, 0, 1, 1, 0, 1, 2'd1, 1'b0, 0, 2'b01, 1, 0);
    step(0, 1, 1, 1, 1, 0, 1, 2'd1, 1'b0, 1, 2'b11, 0, 0);
    idle(1'b0);
    idle(1'b0);

    // Write, BANK=0, N_BWR late by 2; BRFSH_N falls during COL
    step(0, 0, 1, 1, 1, 0, 1, 2'd0, 1'b1, 0, 2'b11, 0, 1);
    step(0, 0, 1, 1, 1, 0, 1, 2'd0, 1'b1, 0, 2'b11, 1, 1);
    step(0, 0, 1, 1, 0, 0, 1, 2'd0, 1'b1, 0, 2'b11, 1, 1);
    step(0, 0, 1, 0, 1, 0, 1, 2'd0, 1'b1, 0, 2'b10, 1, 1);
    step(0, 0, 1, 0, 1, 0, 1, 2'd0, 1'b1, 0, 2'b10, 1, 1);
    step(0, 1, 1, 1, 1, 0, 1, 2'd0, 1'b1, 1, 2'b11, 0, 1);
    idle(1'b1);
    idle(1'b1);

    // Request without RAM_EN is not a DRAM cycle
    step(0, 0, 0, 1, 1, 0, 0, 2'd0, 1'b0, 1, 2'b11, 0, 0);

    // Abort in ROW; request held through PRE is only taken from IDLE
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b0, 0, 2'b11, 0, 0);
    step(0, 1, 0, 1, 1, 0, 1, 2'd0, 1'b0, 1, 2'b11, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b0, 1, 2'b11, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b0, 1, 2'b11, 0, 0);
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b0, 0, 2'b11, 0, 0);
    step(0, 1, 1, 1, 1, 0, 1, 2'd0, 1'b0, 1, 2'b11, 0, 0);
    idle(1'b0);
    idle(1'b0);

    // BANK=2 (no such bank) with BRD_N and N_BWR both low: RAS only
    step(0, 0, 0, 0, 1, 0, 1, 2'd2, 1'b0, 0, 2'b11, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1, 2'd2, 1'b0, 0, 2'b11, 1, 0);
    step(0, 0, 0, 0, 1, 0, 1, 2'd2, 1'b0, 0, 2'b11, 1, 0);
    step(0, 1, 1, 1, 1, 0, 1, 2'd2, 1'b0, 1, 2'b11, 0, 0);
    idle(1'b0);
    idle(1'b0);

    // Advance the row extension to 1, then reset in the middle of CAS
    refresh(1'b1, 1'b0);
    refresh(1'b0, 1'b1);
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b1, 0, 2'b11, 0, 1);
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b1, 0, 2'b11, 1, 1);
    step(0, 0, 0, 1, 1, 0, 1, 2'd0, 1'b1, 0, 2'b10, 1, 1);
    step(1, 0, 0, 1, 1, 0, 1, 2'd0, 1'b1, 1, 2'b11, 0, 1);
    // Refresh accepted straight after reset, extension back to 0
    refresh(1'b0, 1'b0);

`ifdef MIOC_REF_WDOG_EN
    step(1, 1, 1, 1, 1, 0, 0, 2'd0, 1'b0, 1, 2'b11, 0, 0);
    checks++;
    if (REF_LATE !== 1'b0) begin
      errors++;
      $display("FAIL ref_late_reset got %b want 0", REF_LATE);
    end
    for (int i = 0; i < 60; i++) idle(1'b0);
    checks++;
    if (REF_LATE !== 1'b0) begin
      errors++;
      $display("FAIL ref_late_early got %b want 0", REF_LATE);
    end
    for (int i = 0; i < 10; i++) idle(1'b0);
    checks++;
    if (REF_LATE !== 1'b1) begin
      errors++;
      $display("FAIL ref_late_set got %b want 1", REF_LATE);
    end
    refresh(1'b0, 1'b0);
    checks++;
    if (REF_LATE !== 1'b1) begin
      errors++;
      $display("FAIL ref_late_sticky got %b want 1", REF_LATE);
    end
`endif

    @(posedge B_PHI);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
